dmem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the single-port data memory (MemRead/MemWrite/a/wd/Funct3/rd interface).
- Requester 0 is the core load/store unit. Requester 1 is the debug/DMA loader.
- Registers the winning request, drives exactly one memory access per transaction, captures read data, and returns a per-port response pulse.

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Optional alignment checking is enabled with `define DMEM_ARB_ALIGN_CHK_EN.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [DM_ADDRESS-1:0] p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    input  logic [2:0]            p0_funct3,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_W-1:0]     p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DM_ADDRESS-1:0] p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    input  logic [2:0]            p1_funct3,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd,
`ifdef DMEM_ARB_ALIGN_CHK_EN
    output logic                  p0_err,
    output logic                  p1_err,
`endif
    output logic                  busy
);

    // state  | meaning
    // IDLE   | no transaction in flight; may grant
    // ACCESS | one memory access from the latched fields
    // RESP   | rvalid on owning port; may grant the next transaction
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rr_last;
    logic                  r_id;
    logic                  r_we;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [2:0]            r_funct3;
    logic                  r_err;
    logic [DATA_W-1:0]     r_p0_rdata;
    logic [DATA_W-1:0]     r_p1_rdata;

    logic                  w_grant;
    logic                  w_win;
    logic                  w_sel_we;
    logic [DM_ADDRESS-1:0] w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic [2:0]            w_sel_funct3;
    logic                  w_chk_fail;
    logic [DATA_W-1:0]     w_cap;

    // On a tie, round-robin favours the port that did not win last.
    always_comb begin
        w_win = 1'b0;
        if (p0_req && p1_req)
            w_win = (FIXED_PRIO != 0) ? 1'b0 : ~r_rr_last;
        else if (p1_req)
            w_win = 1'b1;
    end

    assign w_grant      = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && (p0_req || p1_req);
    assign p0_gnt       = w_grant && !w_win;
    assign p1_gnt       = w_grant && w_win;
    assign w_sel_we     = w_win ? p1_we     : p0_we;
    assign w_sel_addr   = w_win ? p1_addr   : p0_addr;
    assign w_sel_wdata  = w_win ? p1_wdata  : p0_wdata;
    assign w_sel_funct3 = w_win ? p1_funct3 : p0_funct3;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign w_chk_fail = ((w_sel_funct3[1:0] == 2'b01) && w_sel_addr[0]) ||
                        ((w_sel_funct3[1:0] == 2'b10) && (w_sel_addr[1:0] != 2'b00));
    assign p0_err     = (r_state == ST_RESP) && !r_id && r_err;
    assign p1_err     = (r_state == ST_RESP) && r_id && r_err;
`else
    assign w_chk_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = w_grant ? ST_ACCESS : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= 1'b1;
            r_id      <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_funct3  <= '0;
            r_err     <= 1'b0;
        end else if (w_grant) begin
            r_rr_last <= w_win;
            r_id      <= w_win;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_funct3  <= w_sel_funct3;
            r_err     <= w_chk_fail;
        end
    end

    // Stores and blocked accesses report zero read data.
    assign w_cap = (r_we || r_err) ? '0 : mem_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else if (r_state == ST_ACCESS) begin
            if (r_id)
                r_p1_rdata <= w_cap;
            else
                r_p0_rdata <= w_cap;
        end
    end

    assign mem_read   = (r_state == ST_ACCESS) && !r_we && !r_err;
    assign mem_write  = (r_state == ST_ACCESS) && r_we && !r_err;
    assign mem_a      = r_addr;
    assign mem_wd     = r_wdata;
    assign mem_funct3 = r_funct3;
    assign p0_rvalid  = (r_state == ST_RESP) && !r_id;
    assign p1_rvalid  = (r_state == ST_RESP) && r_id;
    assign p0_rdata   = r_p0_rdata;
    assign p1_rdata   = r_p1_rdata;
    assign busy       = (r_state != ST_IDLE);

endmodule
